// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble packer and the nibble-range adder:
// geometry, state encoding and the slot-to-bit-offset mapping.
package nibble_pkg;
   localparam int NIB_W   = 4;
   localparam int NIB_CNT = 8;
   localparam int SUM_W   = 8;
   localparam int IDX_W   = $clog2(NIB_CNT);
   localparam int WORD_W  = NIB_W * NIB_CNT;
   localparam int OFF_W   = $clog2(WORD_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Slot i occupies bits [slot_off(i) +: NIB_W]
   function automatic logic [OFF_W-1:0] slot_off(input logic [IDX_W-1:0] i);
      return OFF_W'(i) * OFF_W'(NIB_W);
   endfunction
endpackage

// File: rtl/nibble_range_order.sv
// Orders two slot bounds into lo/hi; shared with the nibble-range adder.
module nibble_range_order
   import nibble_pkg::*;
#(
   parameter int W = IDX_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi
);
   logic a_lt_b;

   assign a_lt_b = (a < b);
   assign lo     = a_lt_b ? a : b;
   assign hi     = a_lt_b ? b : a;
endmodule

// File: rtl/nibble_pack_writer.sv
// Packs a valid/ready stream of nibbles into slots lo..hi of a word and
// keeps the running sum, so the adder can re-derive it from the same word.
module nibble_pack_writer
   import nibble_pkg::*;
#(
   parameter int NIB_W   = 4,
   parameter int NIB_CNT = 8,
   parameter int SUM_W   = 8,
   localparam int IW     = $clog2(NIB_CNT)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [IW-1:0]            M,
   input  logic [IW-1:0]            m,
   input  logic [NIB_W-1:0]         din,
   input  logic                     din_valid,
   output logic                     din_ready,
   output logic [NIB_W*NIB_CNT-1:0] Iout,
   output logic [SUM_W-1:0]         sum,
   output logic                     busy,
   output logic                     done
);
   state_t        state, state_nx;
   logic [IW-1:0] lo, hi, hi_q, idx;
   logic          accept;

   nibble_range_order #(.W(IW)) u_order (
      .a  (M),
      .b  (m),
      .lo (lo),
      .hi (hi)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Handshake outputs decode the state register only, never din_valid.
   always_comb begin
      state_nx  = state;
      din_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = LOAD;
         end
         LOAD: begin
            din_ready = 1'b1;
            if (din_valid && idx == hi_q) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign accept = din_valid && din_ready;

   // Slots outside lo..hi are never touched, so consecutive sequences compose.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Iout <= '0;
         sum  <= '0;
         idx  <= '0;
         hi_q <= '0;
      end else if (state == IDLE && start) begin
         idx  <= lo;
         hi_q <= hi;
         sum  <= '0;
      end else if (accept) begin
         Iout[slot_off(idx) +: NIB_W] <= din;
         sum                          <= sum + SUM_W'(din);
         if (idx != hi_q) idx <= idx + IW'(1);
      end
   end
endmodule

// File: tb/tb_nibble_pack_writer.sv
// Scoreboarded random bench: a slot-array model predicts word, sum and the
// done cycle for each sequence; a negedge monitor checks every done pulse.
module tb_nibble_pack_writer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  M = '0, m = '0;
   logic [3:0]  din = '0;
   logic        din_valid = 1'b0;
   logic        din_ready, busy, done;
   logic [31:0] Iout;
   logic [7:0]  sum;

   nibble_pack_writer dut (
      .clk(clk), .rst(rst), .start(start), .M(M), .m(m), .din(din),
      .din_valid(din_valid), .din_ready(din_ready), .Iout(Iout), .sum(sum),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] word;
      logic [7:0]  s;
      int          at;
   } exp_t;
   exp_t q[$];

   int vectors = 0, miscompares = 0;
   logic [3:0] model[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_word();
      logic [31:0] w = '0;
      for (int j = 0; j < 8; j++) w[4*j +: 4] = model[j];
      return w;
   endfunction

   always @(negedge clk) begin
      if (rst && done) begin
         chk("ready_in_done", {31'b0, din_ready}, 32'd0);
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("Iout", Iout, e.word);
            chk("sum", {24'b0, sum}, {24'b0, e.s});
            chk("done_cycle", cyc, e.at);
         end
      end
   end

   // stall_mode: 0 none, 1 one idle cycle before every nibble but the first,
   // 2 random 0..2 idle cycles. ghost injects ignored start pulses while busy.
   task automatic run_seq(input logic [2:0] a, input logic [2:0] b,
                          input logic [3:0] d[8], input int stall_mode, input bit ghost);
      int lo, hi, n, stalls, c0;
      int st[8];
      exp_t e;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      n  = hi - lo + 1;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         st[i] = (stall_mode == 1) ? (i > 0 ? 1 : 0) :
                 (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         stalls += st[i];
      end
      e.s = '0;
      for (int i = 0; i < n; i++) begin
         model[lo + i] = d[i];
         e.s += 8'(d[i]);
      end
      e.word = model_word();

      @(negedge clk);
      c0 = cyc + 1;
      // Done cycle begins at the edge of the last accept: t0 + N + stalls.
      e.at = c0 + n + stalls;
      q.push_back(e);
      start = 1'b1; M = a; m = b; din_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < st[i]; k++) begin
            @(negedge clk);
            start = ghost & $urandom_range(0, 1);
            M = 3'($urandom); m = 3'($urandom);
            din_valid = 1'b0; din = 4'($urandom);
         end
         @(negedge clk);
         start = ghost & $urandom_range(0, 1);
         M = 3'($urandom); m = 3'($urandom);
         din_valid = 1'b1; din = d[i];
      end
      @(negedge clk);
      chk("done_now", {31'b0, done}, 32'd1);
      start = 1'b1; din_valid = 1'b1; din = 4'($urandom);
      M = 3'($urandom); m = 3'($urandom);
      @(negedge clk);
      chk("idle_after_done", {31'b0, busy}, 32'd0);
      start = 1'b0; din_valid = 1'b1; din = 4'($urandom);
      @(negedge clk);
      din_valid = 1'b0;
   endtask

   initial begin
      logic [3:0] d[8];
      for (int j = 0; j < 8; j++) model[j] = '0;

      repeat (5) @(negedge clk);
      chk("rst_Iout", Iout, 32'd0);
      chk("rst_flags", {28'b0, busy, din_ready, done, 1'b0}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_Iout", Iout, 32'd0);
      chk("post_rst_sum", {24'b0, sum}, 32'd0);
      chk("post_rst_flags", {29'b0, busy, din_ready, done}, 32'd0);

      d = '{4'hA, 0, 0, 0, 0, 0, 0, 0};
      run_seq(3'd6, 3'd6, d, 0, 1'b0);
      chk("single_word", Iout, 32'h0A000000);

      d = '{4'h3, 4'hF, 0, 0, 0, 0, 0, 0};
      run_seq(3'd7, 3'd6, d, 0, 1'b0);
      chk("reversed_word", Iout, 32'hF3000000);

      d = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
      run_seq(3'd0, 3'd7, d, 1, 1'b0);
      chk("full_sum", {24'b0, sum}, 32'h78);

      d = '{4'h1, 4'h2, 0, 0, 0, 0, 0, 0};
      run_seq(3'd1, 3'd2, d, 2, 1'b1);
      chk("compose_word", Iout, 32'hFFFFF21F);
      chk("compose_sum", {24'b0, sum}, 32'h03);

      // Reset in the middle of a sequence discards the partial word.
      @(negedge clk);
      start = 1'b1; M = 3'd0; m = 3'd4;
      @(negedge clk);
      start = 1'b0; din_valid = 1'b1; din = 4'h5;
      @(negedge clk);
      din = 4'h9;
      @(negedge clk);
      din_valid = 1'b0;
      model[0] = 4'h5; model[1] = 4'h9;
      chk("partial_word", Iout, model_word());
      #2 rst = 1'b0;
      #1;
      chk("midrst_Iout", Iout, 32'd0);
      chk("midrst_sum", {24'b0, sum}, 32'd0);
      chk("midrst_flags", {29'b0, busy, din_ready, done}, 32'd0);
      for (int j = 0; j < 8; j++) model[j] = '0;
      @(negedge clk);
      rst = 1'b1;

      for (int t = 0; t < 30; t++) begin
         for (int j = 0; j < 8; j++) d[j] = 4'($urandom);
         run_seq(3'($urandom), 3'($urandom), d, int'($urandom_range(0, 2)),
                 1'($urandom));
      end

      repeat (4) @(negedge clk);
      chk("pending_done", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/nibble_pack_writer.md
# nibble_pack_writer

Producer-side counterpart of the nibble-range adder. It accepts a stream of 4-bit nibbles over a valid/ready handshake and writes them into nibble slots `lo..hi` of a 32-bit word, where `lo = min(M,m)` and `hi = max(M,m)`. Once the range is complete it presents the packed word `Iout` and the 8-bit sum of the written nibbles. Feeding `Iout`, `M` and `m` to the adder must then reproduce that sum, which gives a self-checking loop in the processor datapath.

## Interface
Parameters:
- NIB_W, 4, nibble width in bits
- NIB_CNT, 8, nibble slots per word
- SUM_W, 8, sum width; covers 8 × 15 = 120 without overflow

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a write sequence; sampled only in IDLE
- M  in  3  range bound A
- m  in  3  range bound B
- din  in  4  nibble data
- din_valid  in  1  `din` is valid
- din_ready  out  1  block accepts `din` this cycle
- Iout  out  32  packed word; slot i occupies bits [4i+3:4i]
- sum  out  8  running sum of the nibbles written in the current or last sequence
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse when the range is complete

## Operation
- States: IDLE, LOAD, DONE.
- IDLE:
  - On `start=1`, latch `lo=min(M,m)`, `hi=max(M,m)` and `idx=lo`, clear `sum` to 0, then go to LOAD.
  - `M` and `m` are ignored at all other times.
- LOAD:
  - `din_ready=1`.
  - Each accept (`din_valid && din_ready`) writes `din` into slot `idx` and adds `sum += {4'b0,din}`.
  - If `idx==hi`, go to DONE; otherwise `idx++`.
  - `din_valid=0` stalls: no state change and no write.
- DONE:
  - `done=1` and `din_ready=0`; go to IDLE next cycle.
- Slots outside `lo..hi` keep their previous contents, so consecutive sequences compose a word.
- `M==m` writes exactly one nibble.
- `start` while `busy` is ignored. `start` in the DONE cycle is also ignored; it is honoured only in IDLE.
- `din_valid` in IDLE or DONE is ignored (`din_ready=0`).

## Timing
- Reset (`rst=0`, asynchronous):
  - State goes to IDLE, effective immediately.
  - `Iout=0`, `sum=0`, `idx=0`, `din_ready=0`, `busy=0`, `done=0`.
  - Applies mid-sequence as well: any partially written word is discarded.
- Handshake:
  - `din_ready` is a registered function of state only; it never depends combinationally on `din_valid`.
  - `Iout` and `sum` update on the clock edge of each accept.
- Latency:
  - `start` sampled at edge t0 puts the block in LOAD from t0.
  - With `din_valid` held high, N = hi−lo+1 nibbles are accepted at edges t1..tN.
  - `done` is high during the cycle after tN; IDLE follows at edge tN+1.
  - Best case from `start` to `done`: N+1 cycles. Each stall cycle adds 1.
- `Iout` and `sum` are stable from the `done` cycle until the next accept.
- `idx` never wraps: LOAD exits at `hi ≤ 7`.

## Structure
- Shared package `nibble_pkg` holds:
  - NIB_W, NIB_CNT, SUM_W
  - the state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2)
  - the slot-offset helper (`idx*NIB_W`)
- The package is shared with the adder so both sides use the same slot mapping.
- One sub-module, `nibble_range_order`: combinational min/max of `M` and `m`, producing `lo` and `hi`. The adder reuses it.

## Test plan
- Reset: hold `rst=0` for 5 cycles, then release → `Iout=0`, `sum=0`, `busy=0`, `din_ready=0`, `done=0`.
- Single slot: `M=m=6`, `din=0xA` → `Iout=0x0A000000`, `sum=0x0A`; `done` pulses once, 2 cycles after the `start` edge.
- Reversed bounds: `M=7`, `m=6`, then din 0x3 followed by 0xF → `Iout=0xF3000000`, `sum=0x12`. Feeding this `Iout` to the adder gives Y=0x12.
- Full range with stalls: `M=0`, `m=7`, eight nibbles of 0xF with `din_valid` low on every other cycle → `Iout=0xFFFFFFFF`, `sum=0x78`; `done` is 16 cycles after `start`.
- Compose and ignore:
  - After the previous test, run `M=1`, `m=2`, din 0x1 then 0x2 → `Iout=0xFFFFF21F`, `sum=0x03`.
  - A `start` pulse issued mid-sequence has no effect.
- Reset mid-op: `M=0`, `m=4`, assert `rst` after 2 accepts → `Iout=0`, `sum=0`, state IDLE. A new `start` then works normally.
